pix_stream_arbiter: RTL and testbench

Frame-aligned arbiter sharing the single VGA pixel path between two pixel producers, such as a PPU instance and a host/passthrough stream. It sits between the producers' stb/ack outputs and the `vga_driver` input. It switches sources only at frame boundaries. On every switch and after reset it injects a sync token, which realigns the downstream raster counters and pulses `sync_o` back to the producers. It masks bits [1:0] of pixel data so producer data can never alias the sync token.

---
 rtl/pix_arb_pkg.sv | 36 +++
 rtl/pix_stream_arbiter_if.sv | 16 +
 rtl/pix_pos_counter.sv | 50 +++++
 rtl/pix_stream_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_pix_stream_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pix_arb_pkg.sv
// pix_arb_pkg
// Shared definitions for the pixel stream arbiter:
//   - arbiter state encoding (S_SYNC / S_STREAM)
//   - SYNC_TOKEN, the reserved data word that realigns downstream raster counters
//   - default raster geometry (H_TOTAL / V_TOTAL) and frames per grant
//   - pixel field bit positions {R[7:6], G[5:4], B[3:2], x[1:0]}
//   - mask_pixel(): clears the reserved low bits so pixel data never aliases SYNC_TOKEN
package pix_arb_pkg;

    localparam int DEF_H_TOTAL        = 800;
    localparam int DEF_V_TOTAL        = 525;
    localparam int DEF_FRAMES_PER_SRC = 4;
    localparam int POS_W              = 10;
    localparam int PIX_W              = 8;

    // Pixel field LSB positions
    localparam int PIX_R_LSB = 6;
    localparam int PIX_G_LSB = 4;
    localparam int PIX_B_LSB = 2;
    localparam int PIX_X_LSB = 0;

    localparam logic [PIX_W-1:0] SYNC_TOKEN    = 8'h03;
    // Keeps R/G/B, zeroes the x field
    localparam logic [PIX_W-1:0] PIX_KEEP_MASK = 8'hFF << PIX_B_LSB;

    typedef enum logic {
        S_SYNC   = 1'b0,
        S_STREAM = 1'b1
    } arb_state_e;

    // Producer data with the x field forced to zero
    function automatic logic [PIX_W-1:0] mask_pixel(input logic [PIX_W-1:0] raw);
        return raw & PIX_KEEP_MASK;
    endfunction

endpackage

// File: rtl/pix_stream_arbiter_if.sv
// pix_stream_arbiter_if
// Valid/accept pixel stream: data + stb from the producer, ack from the consumer.
// stb is held until ack; ack marks the transfer.
//   master : producer side (drives data, stb; receives ack)
//   slave  : consumer side (receives data, stb; drives ack)
interface pix_stream_arbiter_if;
    import pix_arb_pkg::*;

    logic [PIX_W-1:0] data;
    logic             stb;
    logic             ack;

    modport master (output data, output stb, input  ack);
    modport slave  (input  data, input  stb, output ack);

endinterface

// File: rtl/pix_pos_counter.sv
// pix_pos_counter
// Raster position counter: sx counts pixels within a line, sy counts lines.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear of sx/sy (takes priority over en)
//   en       : advance one pixel
//   last     : high while the position is the final pixel of the frame
module pix_pos_counter
    import pix_arb_pkg::*;
#(
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);

    logic [POS_W-1:0] sx_r;
    logic [POS_W-1:0] sy_r;

    // Position registers: sx wraps at line end and carries into sy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_r <= 10'd0;
            sy_r <= 10'd0;
        end else if (clr) begin
            sx_r <= 10'd0;
            sy_r <= 10'd0;
        end else if (en) begin
            if (sx_r == H_LAST) begin
                sx_r <= 10'd0;
                sy_r <= (sy_r == V_LAST) ? 10'd0 : sy_r + 10'd1;
            end else begin
                sx_r <= sx_r + 10'd1;
                sy_r <= sy_r;
            end
        end else begin
            sx_r <= sx_r;
            sy_r <= sy_r;
        end
    end

    assign last = (sx_r == H_LAST) && (sy_r == V_LAST);

endmodule

// File: rtl/pix_stream_arbiter.sv
// pix_stream_arbiter
// Frame-aligned arbiter sharing one pixel sink between two producers. Sources
// switch only at frame boundaries; every switch (and reset) emits SYNC_TOKEN
// first so the sink realigns its raster counters, then sync_o pulses.
// Optional build macro PIX_ARB_ROUNDROBIN_EN: grant alternates every
// FRAMES_PER_SRC frames and sel is ignored; without it the next grant is sel.
//   clk, rst          : clock, asynchronous active-low reset
//   sel               : requested source, applied at frame boundaries
//   src0, src1        : producer streams (slave side)
//   sink              : output stream toward the VGA driver (master side)
//   sync_o            : one-cycle pulse after SYNC_TOKEN is accepted
//   grant_o           : currently granted source
//   frame_done_o      : one-cycle pulse after the last pixel of a frame is accepted
module pix_stream_arbiter
    import pix_arb_pkg::*;
#(
    parameter int H_TOTAL        = DEF_H_TOTAL,
    parameter int V_TOTAL        = DEF_V_TOTAL,
    parameter int FRAMES_PER_SRC = DEF_FRAMES_PER_SRC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sel,
    pix_stream_arbiter_if.slave  src0,
    pix_stream_arbiter_if.slave  src1,
    pix_stream_arbiter_if.master sink,
    output logic                 sync_o,
    output logic                 grant_o,
    output logic                 frame_done_o
);

    arb_state_e       state_r, state_nxt_s;
    logic [PIX_W-1:0] data_r, data_nxt_s;
    logic             stb_r, stb_nxt_s;
    logic             ack0_r, ack0_nxt_s;
    logic             ack1_r, ack1_nxt_s;
    logic             sync_r, sync_nxt_s;
    logic             grant_r, grant_nxt_s;
    logic             fdone_r, fdone_nxt_s;

    logic             pos_en_s, pos_clr_s, last_s;
    logic             accept_s, free_s, switch_s, frame_end_s, next_grant_s;
    logic             gnt_stb_s, gnt_ack_s;
    logic [PIX_W-1:0] gnt_data_s;

    pix_pos_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (pos_clr_s),
        .en   (pos_en_s),
        .last (last_s)
    );

    assign accept_s    = stb_r & sink.ack;
    // Output register can take a new word when empty or being emptied this cycle
    assign free_s      = ~stb_r | sink.ack;
    assign frame_end_s = (state_r == S_STREAM) & accept_s & last_s;

    assign gnt_stb_s  = grant_r ? src1.stb  : src0.stb;
    assign gnt_data_s = grant_r ? src1.data : src0.data;
    // While the ack pulse is out the source still shows the old stb
    assign gnt_ack_s  = grant_r ? ack1_r    : ack0_r;

`ifdef PIX_ARB_ROUNDROBIN_EN
    logic [15:0] fcnt_r;
    logic        rr_wrap_s;

    assign rr_wrap_s    = (fcnt_r == 16'(FRAMES_PER_SRC - 1));
    assign next_grant_s = rr_wrap_s ? ~grant_r : grant_r;

    // Frames served by the current grant; clears when the grant toggles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt_r <= 16'd0;
        end else if (frame_end_s) begin
            fcnt_r <= rr_wrap_s ? 16'd0 : fcnt_r + 16'd1;
        end else begin
            fcnt_r <= fcnt_r;
        end
    end
`else
    assign next_grant_s = sel;
`endif

    // Next-state and next-output logic for the SYNC/STREAM controller
    always_comb begin
        state_nxt_s = state_r;
        data_nxt_s  = data_r;
        stb_nxt_s   = stb_r;
        ack0_nxt_s  = 1'b0;
        ack1_nxt_s  = 1'b0;
        sync_nxt_s  = 1'b0;
        fdone_nxt_s = 1'b0;
        grant_nxt_s = grant_r;
        pos_en_s    = 1'b0;
        pos_clr_s   = 1'b0;
        switch_s    = 1'b0;
        case (state_r)
            S_SYNC: begin
                if (!stb_r) begin
                    data_nxt_s = SYNC_TOKEN;
                    stb_nxt_s  = 1'b1;
                end else if (sink.ack) begin
                    stb_nxt_s   = 1'b0;
                    pos_clr_s   = 1'b1;
                    sync_nxt_s  = 1'b1;
                    state_nxt_s = S_STREAM;
                end else begin
                    stb_nxt_s = 1'b1;
                end
            end
            S_STREAM: begin
                if (accept_s) begin
                    stb_nxt_s = 1'b0;
                    pos_en_s  = 1'b1;
                    if (last_s) begin
                        fdone_nxt_s = 1'b1;
                        if (next_grant_s != grant_r) begin
                            grant_nxt_s = next_grant_s;
                            state_nxt_s = S_SYNC;
                            switch_s    = 1'b1;
                        end else begin
                            switch_s = 1'b0;
                        end
                    end else begin
                        fdone_nxt_s = 1'b0;
                    end
                end else begin
                    stb_nxt_s = stb_r;
                end
                // A switching boundary must not pull a pixel from the old source
                if (!switch_s && free_s && gnt_stb_s && !gnt_ack_s) begin
                    data_nxt_s = mask_pixel(gnt_data_s);
                    stb_nxt_s  = 1'b1;
                    if (grant_r) begin
                        ack1_nxt_s = 1'b1;
                    end else begin
                        ack0_nxt_s = 1'b1;
                    end
                end else begin
                    data_nxt_s = data_r;
                end
            end
            default: begin
                state_nxt_s = S_SYNC;
                stb_nxt_s   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_SYNC;
            data_r  <= 8'h00;
            stb_r   <= 1'b0;
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            sync_r  <= 1'b0;
            grant_r <= 1'b0;
            fdone_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            data_r  <= data_nxt_s;
            stb_r   <= stb_nxt_s;
            ack0_r  <= ack0_nxt_s;
            ack1_r  <= ack1_nxt_s;
            sync_r  <= sync_nxt_s;
            grant_r <= grant_nxt_s;
            fdone_r <= fdone_nxt_s;
        end
    end

    assign sink.data    = data_r;
    assign sink.stb     = stb_r;
    assign src0.ack     = ack0_r;
    assign src1.ack     = ack1_r;
    assign sync_o       = sync_r;
    assign grant_o      = grant_r;
    assign frame_done_o = fdone_r;

endmodule

// File: tb/tb_pix_stream_arbiter.sv
// tb_pix_stream_arbiter
// Directed bench for pix_stream_arbiter with a 4x2 raster (8 pixels per frame).
// Two PPU-style producers (one pixel per 3 cycles, stb dropped the edge after ack)
// feed the arbiter; a monitor logs every accepted sink word and pulse counts.
module tb_pix_stream_arbiter;

    localparam int HT  = 4;
    localparam int VT  = 2;
    localparam int FPS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic sink_ack = 1'b0;
    logic sync_o, grant_o, frame_done_o;

    pix_stream_arbiter_if src0_if();
    pix_stream_arbiter_if src1_if();
    pix_stream_arbiter_if sink_if();

    logic       pstb[2]   = '{1'b0, 1'b0};
    logic [7:0] pdata[2]  = '{8'h00, 8'h00};
    logic       pack[2];
    int         pseq[2]   = '{0, 0};
    int         plimit[2] = '{0, 3};
    logic       p0_fixed_en = 1'b0;
    logic [7:0] p0_fixed    = 8'h00;

    assign src0_if.stb  = pstb[0];
    assign src0_if.data = pdata[0];
    assign src1_if.stb  = pstb[1];
    assign src1_if.data = pdata[1];
    assign pack[0]      = src0_if.ack;
    assign pack[1]      = src1_if.ack;
    assign sink_if.ack  = sink_ack;

    pix_stream_arbiter #(
        .H_TOTAL        (HT),
        .V_TOTAL        (VT),
        .FRAMES_PER_SRC (FPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sel          (sel),
        .src0         (src0_if),
        .src1         (src1_if),
        .sink         (sink_if),
        .sync_o       (sync_o),
        .grant_o      (grant_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] acc_q[$];
    logic       accg_q[$];
    int ack0_cnt = 0, ack1_cnt = 0, sync_cnt = 0, fd_cnt = 0;

    // Monitor: ack_o is stable from the previous +1 until the next edge
    always @(negedge clk) begin
        if (rst) begin
            if (sink_if.stb && sink_ack) begin
                acc_q.push_back(sink_if.data);
                accg_q.push_back(grant_o);
            end
            if (src0_if.ack)  ack0_cnt++;
            if (src1_if.ack)  ack1_cnt++;
            if (sync_o)       sync_cnt++;
            if (frame_done_o) fd_cnt++;
        end
    end

    task automatic run_producer(input int n);
        int gap = 0;
        forever begin
            @(posedge clk);
            #2;
            if (pstb[n] && pack[n]) begin
                pstb[n] = 1'b0;
                pseq[n]++;
                gap = 1;
            end else if (!pstb[n] && gap > 0) begin
                gap--;
            end else if (!pstb[n] && pseq[n] < plimit[n]) begin
                pstb[n] = 1'b1;
                if (n == 0) pdata[n] = p0_fixed_en ? p0_fixed : {1'b0, pseq[n][4:0], 2'b10};
                else        pdata[n] = {1'b1, pseq[n][4:0], 2'b01};
            end
        end
    endtask

    initial run_producer(0);
    initial run_producer(1);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input int budget, output bit ok);
        int c = 0;
        while (acc_q.size() < n && c < budget) begin
            step();
            c++;
        end
        ok = (acc_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b0; sink_ack = 1'b1; sel = 1'b0;
        repeat (2) step();
        checks++;
        if ({sink_if.data, sink_if.stb, src0_if.ack, src1_if.ack, sync_o, grant_o, frame_done_o} !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs got data=%h stb=%b ack0=%b ack1=%b sync=%b grant=%b fd=%b want all zero",
                     sink_if.data, sink_if.stb, src0_if.ack, src1_if.ack, sync_o, grant_o, frame_done_o);
        end
        checks++;
        if ({dut.u_pos.sx_r, dut.u_pos.sy_r} !== 20'h0) begin
            failures++; $display("FAIL reset_pos got sx=%0d sy=%0d want 0 0", dut.u_pos.sx_r, dut.u_pos.sy_r);
        end
        acc_q.delete(); accg_q.delete(); fd_cnt = 0; sync_cnt = 0;
        rst = 1'b1;
        step();
        checks++;
        if (sink_if.data !== 8'h03 || sink_if.stb !== 1'b1 || sync_o !== 1'b0) begin
            failures++; $display("FAIL first_token got data=%h stb=%b sync=%b want 03 1 0", sink_if.data, sink_if.stb, sync_o);
        end
        step();
        checks++;
        if (sync_o !== 1'b1 || sink_if.stb !== 1'b0 || grant_o !== 1'b0) begin
            failures++; $display("FAIL sync_pulse got sync=%b stb=%b grant=%b want 1 0 0", sync_o, sink_if.stb, grant_o);
        end
        step();
        checks++;
        if (sync_o !== 1'b0) begin
            failures++; $display("FAIL sync_width got sync=%b want 0", sync_o);
        end
    endtask

    task automatic test_capture_ff();
        bit ok; int bad = 0;
        acc_q.delete(); accg_q.delete(); ack0_cnt = 0; ack1_cnt = 0; sync_cnt = 0;
        p0_fixed = 8'hFF; p0_fixed_en = 1'b1; plimit[0] = pseq[0] + 10;
        step();
        checks++;
        if (sink_if.data !== 8'hFC || sink_if.stb !== 1'b1 || src0_if.ack !== 1'b1 || src1_if.ack !== 1'b0) begin
            failures++; $display("FAIL capture_latency got data=%h stb=%b ack0=%b ack1=%b want FC 1 1 0",
                                 sink_if.data, sink_if.stb, src0_if.ack, src1_if.ack);
        end
        wait_acc(10, 100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL ff_timeout got %0d pixels want 10", acc_q.size()); end
        repeat (4) step();
        foreach (acc_q[i]) if (acc_q[i] !== 8'hFC) bad++;
        checks++;
        if (acc_q.size() != 10 || bad != 0) begin
            failures++; $display("FAIL ff_data got count=%0d bad=%0d want 10 0", acc_q.size(), bad);
        end
        checks++;
        if (ack0_cnt != 10 || ack1_cnt != 0) begin
            failures++; $display("FAIL ff_acks got ack0=%0d ack1=%0d want 10 0", ack0_cnt, ack1_cnt);
        end
    endtask

    task automatic test_stream_seq();
        bit ok; int bad = 0; int s; logic [7:0] e;
        s = pseq[0];
        acc_q.delete(); accg_q.delete(); ack0_cnt = 0; ack1_cnt = 0; sync_cnt = 0;
        p0_fixed_en = 1'b0; plimit[0] = s + 100;
        wait_acc(100, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL seq_timeout got %0d pixels want 100", acc_q.size()); end
        repeat (4) step();
        foreach (acc_q[i]) begin
            e = {1'b0, 5'(s + i), 2'b00};
            if (acc_q[i] !== e) bad++;
        end
        checks++;
        if (acc_q.size() != 100 || bad != 0) begin
            failures++; $display("FAIL seq_order got count=%0d bad=%0d want 100 0", acc_q.size(), bad);
        end
        checks++;
        if (ack0_cnt != 100 || ack1_cnt != 0 || sync_cnt != 0) begin
            failures++; $display("FAIL seq_acks got ack0=%0d ack1=%0d sync=%0d want 100 0 0", ack0_cnt, ack1_cnt, sync_cnt);
        end
        checks++;
        if (fd_cnt != 13) begin failures++; $display("FAIL seq_frames got %0d want 13", fd_cnt); end
        checks++;
        if (dut.u_pos.sx_r !== 10'd2 || dut.u_pos.sy_r !== 10'd1) begin
            failures++; $display("FAIL seq_pos got sx=%0d sy=%0d want 2 1", dut.u_pos.sx_r, dut.u_pos.sy_r);
        end
    endtask

    task automatic test_stall();
        bit ok; bit stable = 1'b1; int c = 0; int s; int base; int bad = 0; logic [7:0] e;
        s = pseq[0];
        e = {1'b0, 5'(s), 2'b00};
        acc_q.delete(); accg_q.delete();
        sink_ack = 1'b0; plimit[0] = s + 5;
        while (sink_if.stb !== 1'b1 && c < 10) begin step(); c++; end
        checks++;
        if (sink_if.stb !== 1'b1 || sink_if.data !== e) begin
            failures++; $display("FAIL stall_capture got data=%h stb=%b want %h 1", sink_if.data, sink_if.stb, e);
        end
        step();
        base = ack0_cnt;
        repeat (10) begin
            step();
            if (sink_if.data !== e || sink_if.stb !== 1'b1 || dut.u_pos.sx_r !== 10'd2) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++; $display("FAIL stall_hold got data=%h stb=%b sx=%0d want %h 1 2", sink_if.data, sink_if.stb, dut.u_pos.sx_r, e);
        end
        checks++;
        if (ack0_cnt != base || ack1_cnt != 0) begin
            failures++; $display("FAIL stall_acks got ack0=%0d ack1=%0d want %0d 0", ack0_cnt, ack1_cnt, base);
        end
        sink_ack = 1'b1;
        wait_acc(5, 60, ok);
        repeat (4) step();
        foreach (acc_q[i]) if (acc_q[i] !== {1'b0, 5'(s + i), 2'b00}) bad++;
        checks++;
        if (!ok || acc_q.size() != 5 || bad != 0) begin
            failures++; $display("FAIL stall_resume got count=%0d bad=%0d want 5 0", acc_q.size(), bad);
        end
        checks++;
        if (fd_cnt != 14 || dut.u_pos.sx_r !== 10'd3 || dut.u_pos.sy_r !== 10'd0) begin
            failures++; $display("FAIL stall_pos got fd=%0d sx=%0d sy=%0d want 14 3 0", fd_cnt, dut.u_pos.sx_r, dut.u_pos.sy_r);
        end
    endtask

    task automatic test_switch();
        bit ok; int s; int fd_base; int bad = 0;
        logic [7:0] exp_d[9];
        logic       exp_g[9];
        s = pseq[0];
        for (int i = 0; i < 5; i++) begin exp_d[i] = {1'b0, 5'(s + i), 2'b00}; exp_g[i] = 1'b0; end
        exp_d[5] = 8'h03; exp_g[5] = 1'b1;
        exp_d[6] = 8'h80; exp_d[7] = 8'h84; exp_d[8] = 8'h88;
        exp_g[6] = 1'b1;  exp_g[7] = 1'b1;  exp_g[8] = 1'b1;
        acc_q.delete(); accg_q.delete(); sync_cnt = 0; fd_base = fd_cnt;
        sel = 1'b1; plimit[0] = s + 5;
        wait_acc(2, 30, ok);
        sel = 1'b0;
        wait_acc(3, 30, ok);
        sel = 1'b1;
        checks++;
        if (grant_o !== 1'b0) begin failures++; $display("FAIL grant_mid_frame got %b want 0", grant_o); end
        wait_acc(9, 100, ok);
        repeat (6) step();
        for (int i = 0; i < 9 && i < acc_q.size(); i++)
            if (acc_q[i] !== exp_d[i] || accg_q[i] !== exp_g[i]) bad++;
        checks++;
        if (acc_q.size() != 9 || bad != 0) begin
            failures++; $display("FAIL switch_seq got count=%0d bad=%0d want 9 0", acc_q.size(), bad);
        end
        checks++;
        if (sync_cnt != 1 || (fd_cnt - fd_base) != 1) begin
            failures++; $display("FAIL switch_pulses got sync=%0d fd=%0d want 1 1", sync_cnt, fd_cnt - fd_base);
        end
        checks++;
        if (grant_o !== 1'b1 || dut.u_pos.sx_r !== 10'd3) begin
            failures++; $display("FAIL switch_grant got grant=%b sx=%0d want 1 3", grant_o, dut.u_pos.sx_r);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int s;
        plimit[1] = pseq[1] + 20; plimit[0] = pseq[0] + 20;
        repeat (7) step();
        rst = 1'b0;
        #1;
        checks++;
        if ({sink_if.data, sink_if.stb, src0_if.ack, src1_if.ack, sync_o, grant_o, frame_done_o} !== 14'h0
            || dut.u_pos.sx_r !== 10'd0) begin
            failures++; $display("FAIL mid_reset_outputs got data=%h stb=%b grant=%b sx=%0d want zero",
                                 sink_if.data, sink_if.stb, grant_o, dut.u_pos.sx_r);
        end
        sel = 1'b0;
        repeat (2) step();
        acc_q.delete(); accg_q.delete();
        s = pseq[0];
        rst = 1'b1;
        step();
        checks++;
        if (sink_if.data !== 8'h03 || sink_if.stb !== 1'b1 || grant_o !== 1'b0) begin
            failures++; $display("FAIL mid_restart got data=%h stb=%b grant=%b want 03 1 0", sink_if.data, sink_if.stb, grant_o);
        end
        wait_acc(2, 20, ok);
        checks++;
        if (!ok || acc_q[0] !== 8'h03 || acc_q[1] !== {1'b0, 5'(s), 2'b00} || accg_q[1] !== 1'b0) begin
            failures++; $display("FAIL mid_first_pixels got count=%0d want 03 then %h from src0", acc_q.size(), {1'b0, 5'(s), 2'b00});
        end
    endtask

    task automatic test_roundrobin();
        bit ok; int bad = 0; logic [7:0] d;
        acc_q.delete(); accg_q.delete(); sync_cnt = 0;
        p0_fixed_en = 1'b0;
        plimit[0] = pseq[0] + 40; plimit[1] = pseq[1] + 40;
        wait_acc(36, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rr_timeout got %0d want 36", acc_q.size()); end
        for (int i = 0; i < 36 && i < acc_q.size(); i++) begin
            d = acc_q[i];
            if (i == 16 || i == 33) begin
                if (d !== 8'h03) bad++;
            end else if (i > 16 && i < 33) begin
                if (d[7] !== 1'b1 || d[1:0] !== 2'b00 || accg_q[i] !== 1'b1) bad++;
            end else begin
                if (d[7] !== 1'b0 || d[1:0] !== 2'b00 || accg_q[i] !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rr_pattern got bad=%0d want 0", bad); end
        checks++;
        if (sync_cnt < 2) begin failures++; $display("FAIL rr_syncs got %0d want at least 2", sync_cnt); end
    endtask

    initial begin
        test_reset();
`ifdef PIX_ARB_ROUNDROBIN_EN
        test_roundrobin();
`else
        test_capture_ff();
        test_stream_seq();
        test_stall();
        test_switch();
        test_reset_mid();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
